// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM encodings, the x0 index,
// the per-stage control bundle and the RUN priority rules (branch, load-use, fetch wait).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int REG_X0    = 0;
  localparam int CNT_W_DEF = 32;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;

  // Once the data side is not blocking, a taken branch beats a load-use
  // stall, which beats a fetch wait (an existing stall already holds PC and IF/ID).
  function automatic ctrl_t runRules(input logic brTaken, input logic luHazard,
                                     input logic imemRdy);
    ctrl_t c;
    c.pcEn      = 1'b1;
    c.ifidEn    = 1'b1;
    c.idexEn    = 1'b1;
    c.exmemEn   = 1'b1;
    c.memwbEn   = 1'b1;
    c.ifidFlush = 1'b0;
    c.idexFlush = 1'b0;
    if (brTaken) begin
      c.ifidFlush = 1'b1;
      c.idexFlush = 1'b1;
    end else if (luHazard) begin
      c.pcEn      = 1'b0;
      c.ifidEn    = 1'b0;
      c.idexFlush = 1'b1;
    end else if (!imemRdy) begin
      c.pcEn      = 1'b0;
      c.ifidFlush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline sequencer and the datapath: hazard/wait inputs,
// per-stage enables and flushes, debug state and performance counters.
interface pipe_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] iID_RS1;
  logic [REG_AW-1:0] iID_RS2;
  logic              iID_USE_RS1;
  logic              iID_USE_RS2;
  logic [REG_AW-1:0] iEX_RD;
  logic              iEX_MEMREAD;
  logic              iEX_BR_TAKEN;
  logic              iIMEM_RDY;
  logic              iDMEM_REQ;
  logic              iDMEM_RDY;

  logic              oPC_EN;
  logic              oIFID_EN;
  logic              oIDEX_EN;
  logic              oEXMEM_EN;
  logic              oMEMWB_EN;
  logic              oIFID_FLUSH;
  logic              oIDEX_FLUSH;
  logic [1:0]        oSTATE;
  logic [CNT_W-1:0]  oCYC_CNT;
  logic [CNT_W-1:0]  oSTALL_CNT;
  logic [CNT_W-1:0]  oFLUSH_CNT;

  modport master (
    input  iID_RS1, iID_RS2, iID_USE_RS1, iID_USE_RS2, iEX_RD, iEX_MEMREAD,
           iEX_BR_TAKEN, iIMEM_RDY, iDMEM_REQ, iDMEM_RDY,
    output oPC_EN, oIFID_EN, oIDEX_EN, oEXMEM_EN, oMEMWB_EN, oIFID_FLUSH,
           oIDEX_FLUSH, oSTATE, oCYC_CNT, oSTALL_CNT, oFLUSH_CNT
  );

  modport slave (
    output iID_RS1, iID_RS2, iID_USE_RS1, iID_USE_RS2, iEX_RD, iEX_MEMREAD,
           iEX_BR_TAKEN, iIMEM_RDY, iDMEM_REQ, iDMEM_RDY,
    input  oPC_EN, oIFID_EN, oIDEX_EN, oEXMEM_EN, oMEMWB_EN, oIFID_FLUSH,
           oIDEX_FLUSH, oSTATE, oCYC_CNT, oSTALL_CNT, oFLUSH_CNT
  );
endinterface

// File: rtl/pipe_ctrl_lu_hazard_det.sv
// Load-use comparator: a load in EX writing a register the ID instruction reads.
// Purely combinational so the forwarding checks can share it.
module lu_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              useRs1_i,
  input  logic              useRs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              memRead_i,
  output logic              hazard_o
);

  logic rdLive;
  logic rs1Hit;
  logic rs2Hit;

  // x0 is hardwired zero, so a load targeting it can never feed anyone.
  assign rdLive   = memRead_i && (rd_i != REG_AW'(REG_X0));
  assign rs1Hit   = useRs1_i && (rs1_i == rd_i);
  assign rs2Hit   = useRs2_i && (rs2_i == rd_i);
  assign hazard_o = rdLive && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: boot delay, data-wait FSM and per-stage enables/flushes.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYC = 2,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic       iCLK,
  input logic       iRST,
  pipe_ctrl_if.master bus
);

  localparam int BOOT_W = $clog2(BOOT_CYC + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] bootCnt_q, bootCnt_d;
  logic              luHazard;
  ctrl_t             ctrl;

  lu_hazard_det #(.REG_AW(REG_AW)) u_lu_hazard_det (
    .rs1_i     (bus.iID_RS1),
    .rs2_i     (bus.iID_RS2),
    .useRs1_i  (bus.iID_USE_RS1),
    .useRs2_i  (bus.iID_USE_RS2),
    .rd_i      (bus.iEX_RD),
    .memRead_i (bus.iEX_MEMREAD),
    .hazard_o  (luHazard)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_BOOT;
      bootCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bootCnt_q <= bootCnt_d;
    end
  end

  // Unused encoding 3 falls into the default arm and behaves as BOOT.
  always_comb begin
    state_d   = state_q;
    bootCnt_d = bootCnt_q;
    ctrl      = CTRL_FREEZE;
    case (state_q)
      ST_RUN: begin
        if (bus.iDMEM_REQ && !bus.iDMEM_RDY) begin
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl = runRules(bus.iEX_BR_TAKEN, luHazard, bus.iIMEM_RDY);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.iDMEM_RDY) begin
          ctrl    = runRules(bus.iEX_BR_TAKEN, luHazard, bus.iIMEM_RDY);
          state_d = ST_RUN;
        end
      end
      default: begin
        bootCnt_d = bootCnt_q + 1'b1;
        if (bootCnt_q >= BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
    endcase
    if (iRST) begin
      ctrl = CTRL_FREEZE;
    end
  end

  assign bus.oPC_EN      = ctrl.pcEn;
  assign bus.oIFID_EN    = ctrl.ifidEn;
  assign bus.oIDEX_EN    = ctrl.idexEn;
  assign bus.oEXMEM_EN   = ctrl.exmemEn;
  assign bus.oMEMWB_EN   = ctrl.memwbEn;
  assign bus.oIFID_FLUSH = ctrl.ifidFlush;
  assign bus.oIDEX_FLUSH = ctrl.idexFlush;
  assign bus.oSTATE      = state_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycCnt_q;
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] flushCnt_q;
  logic             active;
  logic             branchFire;

  // Only the branch rule flushes both IF/ID and ID/EX at once.
  assign active     = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
  assign branchFire = ctrl.ifidFlush && ctrl.idexFlush;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cycCnt_q   <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (active) begin
      cycCnt_q <= cycCnt_q + 1'b1;
      if (!ctrl.pcEn) begin
        stallCnt_q <= stallCnt_q + 1'b1;
      end
      if (branchFire) begin
        flushCnt_q <= flushCnt_q + 1'b1;
      end
    end
  end

  assign bus.oCYC_CNT   = cycCnt_q;
  assign bus.oSTALL_CNT = stallCnt_q;
  assign bus.oFLUSH_CNT = flushCnt_q;
`else
  assign bus.oCYC_CNT   = '0;
  assign bus.oSTALL_CNT = '0;
  assign bus.oFLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: hand-computed enables/flushes/state per cycle,
// with counter expectations that wrap at 4 bits (zero when PIPE_CTRL_PERF_CNT_EN is undefined).
module tb_pipe_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic clock;
  logic reset;
  int   errCnt;
  int   chkCnt;
  logic [CNT_W-1:0] modelCyc, modelStall, modelFlush;

  pipe_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.BOOT_CYC(2), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .iCLK (clock),
    .iRST (reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, then advances past the edge.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic im,
                               input logic dq, input logic dr,
                               input logic [4:0] expEn, input logic [1:0] expFl,
                               input logic [1:0] expSt);
    logic [CNT_W-1:0] eC, eS, eF;
    @(negedge clock);
    reset            = r;
    bus.iID_RS1      = rs1;
    bus.iID_RS2      = rs2;
    bus.iID_USE_RS1  = u1;
    bus.iID_USE_RS2  = u2;
    bus.iEX_RD       = rd;
    bus.iEX_MEMREAD  = mr;
    bus.iEX_BR_TAKEN = br;
    bus.iIMEM_RDY    = im;
    bus.iDMEM_REQ    = dq;
    bus.iDMEM_RDY    = dr;
    #1;
    checkOutput({tag, ".en"}, 32'({bus.oPC_EN, bus.oIFID_EN, bus.oIDEX_EN, bus.oEXMEM_EN, bus.oMEMWB_EN}), 32'(expEn));
    checkOutput({tag, ".flush"}, 32'({bus.oIFID_FLUSH, bus.oIDEX_FLUSH}), 32'(expFl));
    checkOutput({tag, ".state"}, 32'(bus.oSTATE), 32'(expSt));
`ifdef PIPE_CTRL_PERF_CNT_EN
    eC = modelCyc;
    eS = modelStall;
    eF = modelFlush;
`else
    eC = '0;
    eS = '0;
    eF = '0;
`endif
    checkOutput({tag, ".cyc"}, 32'(bus.oCYC_CNT), 32'(eC));
    checkOutput({tag, ".stall"}, 32'(bus.oSTALL_CNT), 32'(eS));
    checkOutput({tag, ".flushCnt"}, 32'(bus.oFLUSH_CNT), 32'(eF));
    if (r) begin
      modelCyc   = '0;
      modelStall = '0;
      modelFlush = '0;
    end else if (expSt == 2'd1 || expSt == 2'd2) begin
      modelCyc++;
      if (!expEn[4]) modelStall++;
      if (expFl == 2'b11) modelFlush++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle(input string tag, input logic [1:0] expSt, input logic [4:0] expEn);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, expEn, 2'b00, expSt);
  endtask

  initial begin
    errCnt = 0;
    chkCnt = 0;
    modelCyc = '0;
    modelStall = '0;
    modelFlush = '0;
    reset            = 1'b1;
    bus.iID_RS1      = '0;
    bus.iID_RS2      = '0;
    bus.iID_USE_RS1  = 1'b0;
    bus.iID_USE_RS2  = 1'b0;
    bus.iEX_RD       = '0;
    bus.iEX_MEMREAD  = 1'b0;
    bus.iEX_BR_TAKEN = 1'b0;
    bus.iIMEM_RDY    = 1'b1;
    bus.iDMEM_REQ    = 1'b0;
    bus.iDMEM_RDY    = 1'b0;

    // Reset and boot delay
    applyStimulus("rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 2'b00, 2'd0);
    idleCycle("boot0", 2'd0, 5'b00000);
    idleCycle("boot1", 2'd0, 5'b00000);
    idleCycle("run0", 2'd1, 5'b11111);

    // Load-use hazards and the cases that must not stall
    applyStimulus("luRs2", 0, 3, 5, 1, 1, 5, 1, 0, 1, 0, 0, 5'b00111, 2'b01, 2'd1);
    applyStimulus("luX0", 0, 3, 0, 1, 1, 0, 1, 0, 1, 0, 0, 5'b11111, 2'b00, 2'd1);
    applyStimulus("luRs1", 0, 7, 2, 1, 0, 7, 1, 0, 1, 0, 0, 5'b00111, 2'b01, 2'd1);
    applyStimulus("luNoUse", 0, 7, 2, 0, 1, 7, 1, 0, 1, 0, 0, 5'b11111, 2'b00, 2'd1);
    applyStimulus("luNoLoad", 0, 7, 7, 1, 1, 7, 0, 0, 1, 0, 0, 5'b11111, 2'b00, 2'd1);

    // Taken branch, alone and over a fetch wait and a load-use hazard
    applyStimulus("br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11111, 2'b11, 2'd1);
    applyStimulus("brImem", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 2'b11, 2'd1);
    applyStimulus("brLu", 0, 4, 0, 1, 0, 4, 1, 1, 1, 0, 0, 5'b11111, 2'b11, 2'd1);

    // Data wait with a branch held throughout
    applyStimulus("dwRun", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b00000, 2'b00, 2'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("dwWait", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b00000, 2'b00, 2'd2);
    end
    applyStimulus("dwRdyBr", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 5'b11111, 2'b11, 2'd2);
    idleCycle("dwBack", 2'd1, 5'b11111);

    // Fetch waits, then fetch wait combined with load-use
    applyStimulus("imem0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 2'b10, 2'd1);
    applyStimulus("imem1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 2'b10, 2'd1);
    applyStimulus("imemLu", 0, 9, 9, 1, 1, 9, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 2'd1);

    // MEM_WAIT release under load-use and under a fetch wait
    applyStimulus("mwLuA", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'b00, 2'd1);
    applyStimulus("mwLuB", 0, 6, 0, 1, 0, 6, 1, 0, 1, 1, 1, 5'b00111, 2'b01, 2'd2);
    applyStimulus("mwImA", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'b00, 2'd1);
    applyStimulus("mwImB", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b01111, 2'b10, 2'd2);
    idleCycle("mwDone", 2'd1, 5'b11111);

    // Reset in the middle of a data wait
    applyStimulus("rmwA", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'b00, 2'd1);
    applyStimulus("rmwRst", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b00000, 2'b00, 2'd2);
    idleCycle("rmwBoot0", 2'd0, 5'b00000);
    idleCycle("rmwBoot1", 2'd0, 5'b00000);

    // Sixteen RUN cycles wrap the 4-bit cycle counter back to zero
    for (int i = 0; i < 16; i++) begin
      idleCycle("wrap", 2'd1, 5'b11111);
    end
    checkOutput("cycWrap", 32'(bus.oCYC_CNT), 32'd0);
    idleCycle("wrapEnd", 2'd1, 5'b11111);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencer for the 5-stage pipeline built from D_REG pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it drives every register's iEN and the bubble-insert (flush) controls. Inputs are load-use hazards, taken branches and instruction/data memory wait states. It also holds a post-reset boot delay and optional performance counters.

Parameters:
BOOT_CYC, 2, cycles after reset with all enables low before the pipeline runs (min 1)
REG_AW, 5, register-index width
CNT_W, 32, performance counter width

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  reset, synchronous, active-high
iID_RS1  in  REG_AW  rs1 index of instruction in ID
iID_RS2  in  REG_AW  rs2 index of instruction in ID
iID_USE_RS1  in  1  ID instruction reads rs1
iID_USE_RS2  in  1  ID instruction reads rs2
iEX_RD  in  REG_AW  rd of instruction in EX
iEX_MEMREAD  in  1  EX instruction is a load
iEX_BR_TAKEN  in  1  EX resolved a taken branch/jump
iIMEM_RDY  in  1  instruction fetch data valid this cycle
iDMEM_REQ  in  1  MEM stage issues a data access
iDMEM_RDY  in  1  data access completes this cycle
oPC_EN, oIFID_EN, oIDEX_EN, oEXMEM_EN, oMEMWB_EN  out  1 each  D_REG iEN per stage
oIFID_FLUSH  out  1  IF/ID loads a bubble (NOP, valid=0) on this edge
oIDEX_FLUSH  out  1  ID/EX loads a bubble on this edge
oSTATE  out  2  current FSM state (debug)
oCYC_CNT, oSTALL_CNT, oFLUSH_CNT  out  CNT_W each  performance counters

Behaviour:
- States: BOOT=0, RUN=1, MEM_WAIT=2; the value 3 is unused and decodes as BOOT.
- Only the state and the counters are registered. All enable/flush outputs are combinational from state and inputs, valid in the same cycle.
- A flush output is meaningful only when the matching enable is 1. The controller never asserts a flush with its enable low.
- Reset: iRST=1 at an edge sets state=BOOT, clears the boot counter and clears all counters. While iRST=1, all enables and flushes are 0. Reset mid-stall or mid-MEM_WAIT is abandoned with no pending effects.
- BOOT: all enables and flushes are 0. The boot counter increments each cycle. After BOOT_CYC cycles in BOOT, the next state is RUN.
- RUN applies the rules below, first match wins:
  1. iDMEM_REQ && !iDMEM_RDY: all enables 0 (full freeze). Next state MEM_WAIT.
  2. iEX_BR_TAKEN: all enables 1, oIFID_FLUSH=1, oIDEX_FLUSH=1. This squashes the two younger instructions.
  3. Load-use hazard: all enables 1 except oPC_EN=0 and oIFID_EN=0; oIDEX_FLUSH=1.
     - Hazard condition: iEX_MEMREAD && iEX_RD!=0 && ((iID_USE_RS1 && iID_RS1==iEX_RD) || (iID_USE_RS2 && iID_RS2==iEX_RD)).
     - Effect: exactly one bubble per hazard cycle.
  4. !iIMEM_RDY: oPC_EN=0, oIFID_EN=1, oIFID_FLUSH=1; other enables 1. A bubble enters ID.
  5. Otherwise all enables 1, no flush.
- MEM_WAIT:
  - iDMEM_RDY=0: full freeze.
  - iDMEM_RDY=1: outputs follow RUN rules 2-5 using current inputs. Next state RUN.
- Rule 1 outranks a branch because EX is frozen and the branch is re-seen after the wait.
- Rule 3 combined with !iIMEM_RDY: rule 3 applies. The PC and IF/ID are already held, so the fetch wait is absorbed.
- Rule 2 combined with !iIMEM_RDY: rule 2 applies. The redirect overrides the pending fetch.

Optional Feature:
PIPE_CTRL_PERF_CNT_EN
- Defined: counters active, all wrapping modulo 2^CNT_W, all cleared on reset.
  - oCYC_CNT increments every cycle in RUN or MEM_WAIT.
  - oSTALL_CNT increments every cycle with oPC_EN=0 in RUN or MEM_WAIT.
  - oFLUSH_CNT increments on each cycle where rule 2 fires.
- Undefined: the counter ports remain and are tied to 0. No counter flops are synthesized.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encodings ST_BOOT/ST_RUN/ST_MEM_WAIT, 2-bit
  - the x0 register index constant
  - the default CNT_W
- One sub-module, lu_hazard_det: purely combinational rule-3 comparator (rs1/rs2/use/rd/memread in, hazard out). It is reused by the forwarding-unit checks.

Test Plan:
- Reset, then iRST=0 with BOOT_CYC=2: all enables 0 for 2 cycles; cycle 3 oSTATE=1 with all enables 1. Assert iRST=1 mid-run: next edge oSTATE=0 and counters read 0.
- Load-use: EX lw rd=5 (iEX_MEMREAD=1, iEX_RD=5); ID add uses rs2=5 -> oPC_EN=0, oIFID_EN=0, oIDEX_FLUSH=1, oEXMEM_EN=1. Repeat with iEX_RD=0 -> no stall.
- Taken branch, iEX_BR_TAKEN=1 for 1 cycle -> oIFID_FLUSH=oIDEX_FLUSH=1, all enables 1, oFLUSH_CNT +1 when the feature is on.
- Data wait: iDMEM_REQ=1, iDMEM_RDY=0 for 3 cycles, branch asserted throughout -> 1 cycle freeze in RUN plus MEM_WAIT freeze until ready. In the ready cycle the branch flush fires and the state returns to RUN. oSTALL_CNT +4.
- Fetch wait: iIMEM_RDY=0 for 2 cycles -> oPC_EN=0, oIFID_EN=1, oIFID_FLUSH=1 each cycle. Combined with a load-use hazard -> rule-3 outputs.
- Counter wrap with CNT_W=4: 16 RUN cycles -> oCYC_CNT returns to 0. Feature undefined -> all counters stay 0.
